vram_writer: RTL and testbench

//  CPU-side write/read port into the 8 KB text VRAM that the video block scans out.

---
 rtl/vram_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_vram_writer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// vram_writer: CPU register port into the 8 KB text VRAM.
// The CPU sees four registers: ADDR_LO, ADDR_HI, DATA (auto-increment) and STATUS/CTRL.
// CPU writes go into a small FIFO and drain to the VRAM port through a request/grant
// handshake with the arbiter. Writes always drain before any read prefetch.
// Optional feature: define VRAM_WRITER_READBACK_EN to add the DATA read path
// (prefetch, CAPTURE state, RDVALID). Without it DATA reads return 8'hFF.
module vram_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 80
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        SEL,
  input  logic [1:0]  A,
  input  logic        R_W_n,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        VRAM_REQ,
  input  logic        VRAM_GNT,
  output logic        VRAM_WE,
  output logic [12:0] VRAM_A,
  output logic [7:0]  VRAM_D,
  input  logic [7:0]  VRAM_Q,
  output logic        BUSY,
  output logic [1:0]  state_dbg
);

`ifdef VRAM_WRITER_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACCESS  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Architectural registers
  logic [12:0] ptr;
  logic [1:0]  step;
  logic        ovf;
  logic        rdvalid;
  logic [7:0]  rd_buf;
  logic        pf_pending;
  logic        rd_stale;

  // FIFO storage: entry = {addr[12:0], data[7:0]}
  logic [20:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, head_idx;
  logic [CW-1:0] count;

  // Operation currently presented to the VRAM port
  logic        op_rd;
  logic [12:0] op_addr;
  logic [7:0]  op_data;

  // Bus decode: exactly one register access per cycle while SEL is high
  logic wr_lo, wr_hi, wr_data, wr_ctrl, rd_data, rd_status;
  logic full, push, pop, data_rd_adv, pf_sched;
  logic launch_wr, launch_rd, rd_inflight, discard_now;
  logic [12:0] step_amt;
  logic [7:0]  status;

  assign wr_lo     = SEL && !R_W_n && (A == 2'd0);
  assign wr_hi     = SEL && !R_W_n && (A == 2'd1);
  assign wr_data   = SEL && !R_W_n && (A == 2'd2);
  assign wr_ctrl   = SEL && !R_W_n && (A == 2'd3);
  assign rd_data   = SEL &&  R_W_n && (A == 2'd2);
  assign rd_status = SEL &&  R_W_n && (A == 2'd3);

  // FULL is judged on the count before any same-cycle pop
  assign full        = (count == CW'(FIFO_DEPTH));
  assign push        = wr_data && !full;
  assign pop         = (state == S_ACCESS) && !op_rd;
  assign data_rd_adv = RB_EN && rd_data;
  // Events that invalidate the read buffer and ask for a fresh prefetch
  assign pf_sched    = RB_EN && (wr_hi || rd_data);

  // Next head entry: while popping, the entry behind the current head
  assign head_idx = (state == S_ACCESS) ? (rd_ptr + AW'(1)) : rd_ptr;

  // Writes only launch from entries already stored, so a same-cycle push is never
  // needed on the port; a prefetch waits until the FIFO is empty and nothing is arriving.
  assign launch_wr = ((state == S_IDLE) && (count != '0)) ||
                     ((state == S_ACCESS) && !op_rd && (count > CW'(1)));
  assign launch_rd = RB_EN && pf_pending && !push &&
                     (((state == S_IDLE) && (count == '0)) ||
                      ((state == S_ACCESS) && !op_rd && (count == CW'(1))));

  assign rd_inflight = op_rd && (state != S_IDLE);
  assign discard_now = rd_stale || pf_sched;

  // Pointer increment selected by CTRL.STEP
  always_comb begin
    case (step)
      2'b00:   step_amt = 13'd0;
      2'b10:   step_amt = 13'(COLS);
      default: step_amt = 13'd1;
    endcase
  end

  assign BUSY   = (count != '0) || pf_pending || (state != S_IDLE);
  assign status = {4'b0000, rdvalid, ovf, full, BUSY};

  // CPU read data, combinational from the addressed register
  always_comb begin
    case (A)
      2'd0:    DO = ptr[7:0];
      2'd1:    DO = {3'b000, ptr[12:8]};
      2'd2:    DO = RB_EN ? rd_buf : 8'hFF;
      default: DO = status;
    endcase
  end

  // Address pointer, step and sticky overflow flag
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ptr  <= '0;
      step <= 2'b01;
      ovf  <= 1'b0;
    end else begin
      if (wr_lo)                          ptr[7:0]  <= DI;
      else if (wr_hi)                     ptr[12:8] <= DI[4:0];
      else if (push || data_rd_adv)       ptr       <= ptr + step_amt;
      if (wr_ctrl)                        step      <= DI[1:0];
      if (wr_data && full)                ovf       <= 1'b1;
      else if (rd_status)                 ovf       <= 1'b0;
    end
  end

  // FIFO storage array (no reset needed: count guards validity)
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {ptr, DI};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // VRAM port payload, latched when entering REQ and held until the next launch.
  // Handshake: VRAM_REQ is valid and VRAM_GNT is ready; a transfer happens at the
  // rising edge where both are high, and VRAM_A/VRAM_D stay stable while REQ is high.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      op_rd   <= 1'b0;
      op_addr <= '0;
      op_data <= '0;
    end else if (launch_wr) begin
      op_rd   <= 1'b0;
      op_addr <= fifo_mem[head_idx][20:8];
      op_data <= fifo_mem[head_idx][7:0];
    end else if (launch_rd) begin
      op_rd   <= 1'b1;
      op_addr <= ptr;
    end
  end

  assign VRAM_A = op_addr;
  assign VRAM_D = op_data;

  // Read path: prefetch request, stale tracking, read buffer and RDVALID
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      pf_pending <= 1'b0;
      rd_stale   <= 1'b0;
      rdvalid    <= 1'b0;
      rd_buf     <= '0;
    end else begin
      if (pf_sched)       pf_pending <= 1'b1;
      else if (launch_rd) pf_pending <= 1'b0;
      if (launch_rd)                      rd_stale <= pf_sched;
      else if (pf_sched && rd_inflight)   rd_stale <= 1'b1;
      if (pf_sched) begin
        rdvalid <= 1'b0;
      end else if ((state == S_CAPTURE) && !discard_now) begin
        rdvalid <= 1'b1;
        rd_buf  <= VRAM_Q;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state: writes drain back-to-back, a read adds the CAPTURE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (launch_wr || launch_rd) state_nxt = S_REQ;
      S_REQ:     if (VRAM_GNT) state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (op_rd)                        state_nxt = S_CAPTURE;
        else if (launch_wr || launch_rd)  state_nxt = S_REQ;
        else                              state_nxt = S_IDLE;
      end
      S_CAPTURE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    VRAM_REQ  = (state == S_REQ);
    VRAM_WE   = (state == S_ACCESS) && !op_rd;
    state_dbg = state;
  end

endmodule

// File: tb/tb_vram_writer.sv
// Bench for vram_writer: directed scenarios plus randomized register traffic
// against a behavioural model (pointer arithmetic + expected-write queue) and a
// simple synchronous RAM standing in for the VRAM.
module tb_vram_writer;
  localparam int DEPTH  = 4;
  localparam int COLS_P = 80;

  logic        CLK, RESET_n, SEL, R_W_n, VRAM_GNT, VRAM_REQ, VRAM_WE, BUSY;
  logic [1:0]  A, state_dbg;
  logic [7:0]  DI, DO, VRAM_D, VRAM_Q;
  logic [12:0] VRAM_A;

  int total = 0;
  int bad   = 0;

  // Scoreboard / model state
  logic [20:0] exp_q[$];
  int   m_ptr, m_step, we_count;
  bit   m_ovf, req_seen;
  logic [7:0] status_mask;
  logic prev_req, prev_gnt;
  logic [12:0] prev_a;
  logic [7:0]  prev_d;

  // VRAM stand-in
  logic [7:0]  vram_mem [0:8191];
  logic        pre_en;
  logic [12:0] pre_addr;
  logic [7:0]  pre_data;
  int          gnt_mode;

  vram_writer #(.FIFO_DEPTH(DEPTH), .COLS(COLS_P)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .SEL(SEL), .A(A), .R_W_n(R_W_n), .DI(DI), .DO(DO),
    .VRAM_REQ(VRAM_REQ), .VRAM_GNT(VRAM_GNT), .VRAM_WE(VRAM_WE), .VRAM_A(VRAM_A),
    .VRAM_D(VRAM_D), .VRAM_Q(VRAM_Q), .BUSY(BUSY), .state_dbg(state_dbg)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Grant driver: held low, held high, or random
  initial begin
    VRAM_GNT = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (gnt_mode)
        0:       VRAM_GNT = 1'b0;
        1:       VRAM_GNT = 1'b1;
        default: VRAM_GNT = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Synchronous RAM: read data valid one cycle after the access cycle
  always @(posedge CLK) begin
    if (pre_en)       vram_mem[pre_addr] <= pre_data;
    else if (VRAM_WE) vram_mem[VRAM_A]   <= VRAM_D;
    VRAM_Q <= vram_mem[VRAM_A];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int step_val(input int s);
    case (s)
      0:       return 0;
      2:       return COLS_P;
      default: return 1;
    endcase
  endfunction

  // Model + compare, sampled mid-cycle on the falling edge
  always @(negedge CLK) begin
    logic [20:0] e;
    logic [7:0]  exp_status;
    bit          full_m, busy_m;
    if (!RESET_n) begin
      exp_q.delete();
      m_ptr = 0; m_step = 1; m_ovf = 1'b0;
      check("reset_req", VRAM_REQ, 0);
      check("reset_we", VRAM_WE, 0);
      check("reset_busy", BUSY, 0);
      prev_req = 1'b0; prev_gnt = 1'b0;
    end else begin
      full_m = (exp_q.size() == DEPTH);
      busy_m = (exp_q.size() != 0);
      if (VRAM_REQ) req_seen = 1'b1;
      if (prev_req && prev_gnt) check("req_drop_after_gnt", VRAM_REQ, 0);
      if (prev_req && VRAM_REQ) begin
        check("req_addr_stable", VRAM_A, prev_a);
        check("req_data_stable", VRAM_D, prev_d);
      end
      if (VRAM_WE) begin
        we_count++;
        check("we_after_grant", prev_req && prev_gnt, 1);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_we: got write a=0x%0h d=0x%0h expected none", VRAM_A, VRAM_D);
        end else begin
          e = exp_q.pop_front();
          check("vram_a", VRAM_A, e[20:8]);
          check("vram_d", VRAM_D, e[7:0]);
        end
      end
      if (SEL && R_W_n) begin
        case (A)
          2'd0: check("rd_addr_lo", DO, m_ptr & 'hFF);
          2'd1: check("rd_addr_hi", DO, (m_ptr >> 8) & 'h1F);
          2'd2: begin
`ifdef VRAM_WRITER_READBACK_EN
            m_ptr = (m_ptr + step_val(m_step)) % 8192;
`else
            check("rd_data_ff", DO, 8'hFF);
`endif
          end
          default: begin
            exp_status = {4'b0000, 1'b0, m_ovf, full_m, busy_m};
            check("rd_status", DO & status_mask, exp_status & status_mask);
            m_ovf = 1'b0;
          end
        endcase
      end
      if (SEL && !R_W_n) begin
        case (A)
          2'd0: m_ptr = (m_ptr & 'h1F00) | int'(DI);
          2'd1: m_ptr = (m_ptr & 'hFF) | ((int'(DI) & 'h1F) << 8);
          2'd2: begin
            if (full_m) m_ovf = 1'b1;
            else begin
              exp_q.push_back({m_ptr[12:0], DI});
              m_ptr = (m_ptr + step_val(m_step)) % 8192;
            end
          end
          default: m_step = int'(DI[1:0]);
        endcase
      end
      prev_req = VRAM_REQ; prev_gnt = VRAM_GNT;
      prev_a   = VRAM_A;   prev_d   = VRAM_D;
    end
  end

  // Driver tasks: caller sits just after a rising edge
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    SEL = 1'b1; R_W_n = 1'b0; A = a; DI = d;
    @(posedge CLK); #1;
    SEL = 1'b0; R_W_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    SEL = 1'b1; R_W_n = 1'b1; A = a;
    @(negedge CLK);
    d = DO;
    @(posedge CLK); #1;
    SEL = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic set_addr(input int addr);
    bus_wr(2'd0, 8'(addr & 'hFF));
    bus_wr(2'd1, 8'((addr >> 8) & 'h1F));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < budget) begin
      @(posedge CLK); #1; n++;
    end
    check(name, (exp_q.size() == 0) && !BUSY, 1);
  endtask

  task automatic wait_rdvalid(input string name);
    logic [7:0] s;
    int n = 0;
    s = 8'h00;
    while (!s[3] && n < 60) begin
      bus_rd(2'd3, s); n++;
    end
    check(name, s[3], 1);
  endtask

  // Watchdog
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int w0, op;
`ifdef VRAM_WRITER_READBACK_EN
    status_mask = 8'h06;
`else
    status_mask = 8'hFF;
`endif
    SEL = 1'b0; R_W_n = 1'b1; A = 2'd0; DI = 8'h00;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    gnt_mode = 0; RESET_n = 1'b0;
    m_ptr = 0; m_step = 1; m_ovf = 1'b0; we_count = 0; req_seen = 1'b0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_a = '0; prev_d = '0;
    repeat (3) @(posedge CLK);
    #1 RESET_n = 1'b1;

    // Reset state
    check("rst_vram_a", VRAM_A, 13'h0000);
    check("rst_vram_d", VRAM_D, 8'h00);
    check("rst_busy", BUSY, 0);
    bus_rd(2'd3, s); check("rst_status", s, 8'h00);
    bus_rd(2'd0, s); check("rst_addr_lo", s, 8'h00);

    // 1: three writes from 0x0000 with grant tied high
    gnt_mode = 1; w0 = we_count;
    bus_wr(2'd3, 8'h01);
    set_addr(0);
    bus_wr(2'd2, 8'h41); bus_wr(2'd2, 8'h42); bus_wr(2'd2, 8'h43);
    wait_drain("t1_drain", 60);
    check("t1_we_count", we_count - w0, 3);
    check("t1_mem0", vram_mem[0], 8'h41);
    check("t1_mem1", vram_mem[1], 8'h42);
    check("t1_mem2", vram_mem[2], 8'h43);
    bus_rd(2'd3, s); check("t1_busy_low", s[0], 0);

    // 2: grant held low, six writes into a 4-deep FIFO
    gnt_mode = 0;
    set_addr('h0200);
    w0 = we_count;
    for (int i = 0; i < 6; i++) bus_wr(2'd2, 8'(8'h10 + i));
    bus_rd(2'd3, s); check("t2_status_ovf", s & 8'h07, 8'h07);
    bus_rd(2'd3, s); check("t2_status_cleared", s & 8'h07, 8'h03);
    gnt_mode = 1;
    wait_drain("t2_drain", 80);
    check("t2_we_count", we_count - w0, 4);
    check("t2_mem_first", vram_mem['h200], 8'h10);
    check("t2_mem_last", vram_mem['h203], 8'h13);

    // 3: pointer wrap at the top of VRAM
    set_addr('h1FFF);
    bus_wr(2'd2, 8'h31); bus_wr(2'd2, 8'h32);
    wait_drain("t3_drain", 60);
    check("t3_mem_top", vram_mem['h1FFF], 8'h31);
    check("t3_mem_wrap", vram_mem[0], 8'h32);

    // 4: row step
    bus_wr(2'd3, 8'h02);
    set_addr('h0010);
    bus_wr(2'd2, 8'h51); bus_wr(2'd2, 8'h52);
    wait_drain("t4_drain", 60);
    check("t4_mem_row0", vram_mem['h10], 8'h51);
    check("t4_mem_row1", vram_mem['h60], 8'h52);
    bus_wr(2'd3, 8'h01);

    // 5: read path
`ifdef VRAM_WRITER_READBACK_EN
    pre_en = 1'b1; pre_addr = 13'h0100; pre_data = 8'h5A;
    @(posedge CLK); #1;
    pre_addr = 13'h0101; pre_data = 8'hA5;
    @(posedge CLK); #1;
    pre_en = 1'b0;
    set_addr('h0100);
    wait_rdvalid("t5_rdvalid0");
    bus_rd(2'd2, s); check("t5_data0", s, 8'h5A);
    wait_rdvalid("t5_rdvalid1");
    bus_rd(2'd2, s); check("t5_data1", s, 8'hA5);
    bus_rd(2'd0, s); check("t5_ptr_lo", s, 8'h02);
`else
    set_addr('h0100);
    idle(2);
    req_seen = 1'b0;
    bus_rd(2'd2, s); check("t5_data_ff", s, 8'hFF);
    idle(10);
    check("t5_no_req", req_seen, 0);
    bus_rd(2'd0, s); check("t5_ptr_unmoved", s, 8'h00);
`endif

    // 6: reset while requesting with writes queued
    gnt_mode = 0;
    idle(20);
    bus_wr(2'd2, 8'h61); bus_wr(2'd2, 8'h62); bus_wr(2'd2, 8'h63);
    idle(2);
    check("t6_in_req", VRAM_REQ, 1);
    RESET_n = 1'b0;
    #1;
    check("t6_req_drop", VRAM_REQ, 0);
    check("t6_we_drop", VRAM_WE, 0);
    idle(2);
    RESET_n = 1'b1;
    gnt_mode = 1; w0 = we_count;
    idle(10);
    check("t6_no_we", we_count - w0, 0);
    bus_rd(2'd3, s); check("t6_status", s, 8'h00);

    // Randomized register traffic with random grants
    gnt_mode = 2;
    for (int i = 0; i < 700; i++) begin
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3: bus_wr(2'd2, 8'($urandom_range(0, 255)));
        4:          bus_rd(2'd3, s);
        5:          bus_rd(2'd0, s);
        6:          bus_rd(2'd1, s);
        7:          bus_wr(2'd3, 8'($urandom_range(0, 3)));
        8:          bus_wr(2'd0, 8'($urandom_range(0, 255)));
        9:          bus_wr(2'd1, 8'($urandom_range(0, 255)));
        10: begin
`ifdef VRAM_WRITER_READBACK_EN
          bus_rd(2'd3, s);
`else
          bus_rd(2'd2, s);
`endif
        end
        default:    idle(1);
      endcase
    end
    gnt_mode = 1;
    wait_drain("rand_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
